urv_dm_wb_bridge: RTL

Data-memory bus bridge placed directly downstream of the uRV core's data memory interface. It converts the core's one-cycle load/store request strobes into single pipelined-Wishbone master transactions and returns load data plus load-done/store-done completion pulses to the core's writeback stage. It allows one outstanding access and enforces a bus timeout, so a dead slave cannot hang the pipeline.

---
 rtl/urv_dm_wb_bridge_pkg.sv | 30 +++
 rtl/urv_dm_wb_bridge.sv | 131 +++++++++++++
 2 files changed

// File: rtl/urv_dm_wb_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : urv_dm_wb_bridge_pkg
//  Description : Shared types and constants for the uRV data-memory to
//                pipelined-Wishbone bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package urv_dm_wb_bridge_pkg;

    // Bridge state: idle, strobing the request, waiting for the response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } bridge_state_t;

    // Bus cycles allowed before an unanswered access is aborted.
    localparam int C_DEFAULT_TIMEOUT = 255;

    // Width of the saturating timeout counter; never narrower than one bit
    // so a disabled timeout still yields a legal vector.
    function automatic int timeout_cnt_width(input int timeout);
        if (timeout < 1) begin
            return 1;
        end
        return $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/urv_dm_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : urv_dm_wb_bridge
//  Description : Converts uRV data-memory load/store strobes into single
//                pipelined-Wishbone transactions, one outstanding at a time,
//                with a bus timeout and error reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module urv_dm_wb_bridge
    import urv_dm_wb_bridge_pkg::*;
#(
    parameter int g_timeout = C_DEFAULT_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i,
    output logic        bus_err_o,
    output logic [31:0] bus_err_addr_o
);

    localparam int              CNT_W     = timeout_cnt_width(g_timeout);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(g_timeout);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    bridge_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_timeout;
    logic w_fail;
    logic w_finish;

    // Timeout fires only when enabled; a simultaneous ack still counts as a
    // successful transfer, while an explicit err always wins over ack.
    assign w_timeout = (g_timeout != 0) && (r_cnt == C_TIMEOUT);
    assign w_fail    = wb_err_i || (w_timeout && !wb_ack_i);
    assign w_finish  = wb_ack_i || w_fail;

    // Bridge FSM with every output registered.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            dm_ready_o      <= 1'b1;
            dm_data_l_o     <= '0;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            wb_adr_o        <= '0;
            wb_dat_o        <= '0;
            wb_sel_o        <= '0;
            wb_we_o         <= 1'b0;
            wb_cyc_o        <= 1'b0;
            wb_stb_o        <= 1'b0;
            bus_err_o       <= 1'b0;
            bus_err_addr_o  <= '0;
        end else begin
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            bus_err_o       <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (dm_load_i || dm_store_i) begin
                        wb_adr_o   <= dm_addr_i;
                        wb_dat_o   <= dm_data_s_i;
                        wb_sel_o   <= dm_data_select_i;
                        // A combined load+store strobe is served as a load.
                        wb_we_o    <= dm_store_i && !dm_load_i;
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        dm_ready_o <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= ST_REQ;
                    end
                end

                ST_REQ, ST_WAIT: begin
                    if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end

                    if (w_finish) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        dm_ready_o <= 1'b1;
                        r_state    <= ST_IDLE;
                        if (wb_we_o) begin
                            dm_store_done_o <= 1'b1;
                        end else begin
                            dm_load_done_o <= 1'b1;
                            dm_data_l_o    <= w_fail ? 32'h0000_0000 : wb_dat_i;
                        end
                        if (w_fail) begin
                            bus_err_o      <= 1'b1;
                            bus_err_addr_o <= wb_adr_o;
                        end
                    end else if ((r_state == ST_REQ) && !wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        r_state  <= ST_WAIT;
                    end
                end

                default: begin
                    wb_cyc_o   <= 1'b0;
                    wb_stb_o   <= 1'b0;
                    dm_ready_o <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
